latency_mem: RTL and testbench

- Parametrised, cycle-accurate memory model for the multi-cycle MIPS benches.
- Replaces the fixed-delay asynchronous memory with a synchronous request/ready handshake.
- Adds programmable wait states, configurable data width and depth, and byte-enable writes.
- The CPU under test holds a request until `ready`. This lets multi-cycle control FSMs be verified against slow memory.

---
 rtl/latency_mem.sv | 133 +++++++++++++
 tb/tb_latency_mem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/latency_mem.sv
// rtl/latency_mem.sv - synchronous request/ready memory model with programmable wait states
// Byte-enable writes, registered reads, and address wrap modulo the configured depth.
module latency_mem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     read_data,
  output logic                  ready,
  output logic                  busy
);

  localparam int         NB    = DATA_W / 8;
  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NB-1:0]         be_q, be_d;
  logic                  wr_q, wr_d;

  // Operation performed on the edge that enters DONE, so ready and read_data line up.
  logic                  do_op;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [DATA_W-1:0]     op_data;
  logic [NB-1:0]         op_be;
  logic                  op_wr;

  logic [DATA_W-1:0]     mem_data [0:DEPTH-1];
  logic [DATA_W-1:0]     read_data_q;

  logic                  unused_addr;
  assign unused_addr = ^{address[31:DEPTH_LOG2+2], address[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    be_d    = be_q;
    wr_d    = wr_q;
    do_op   = 1'b0;
    op_idx  = idx_q;
    op_data = data_q;
    op_be   = be_q;
    op_wr   = wr_q;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          idx_d  = address[DEPTH_LOG2+1:2];
          data_d = write_data;
          be_d   = byte_en;
          wr_d   = write;
          cnt_d  = LAT;
          if (LAT == 4'd0) begin
            // Zero wait states: act on the live request at acceptance.
            state_d = DONE;
            do_op   = 1'b1;
            op_idx  = address[DEPTH_LOG2+1:2];
            op_data = write_data;
            op_be   = byte_en;
            op_wr   = write;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          do_op   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
    end else if (do_op && !op_wr) begin
      read_data_q <= mem_data[op_idx];
    end
  end

  // Storage is deliberately outside reset so preloaded contents survive it.
  always_ff @(posedge clk) begin
    if (do_op && op_wr && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (op_be[b]) begin
          mem_data[op_idx][8*b +: 8] <= op_data[8*b +: 8];
        end
      end
    end
  end

  assign read_data = read_data_q;
  assign ready     = (state_q == DONE);
  assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_latency_mem.sv
// tb/tb_latency_mem.sv - directed bench for latency_mem
// Three instances: default (LATENCY=2), zero-latency, and 64-bit/16-word.
module tb_latency_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd_a, wr_a, rd_b, wr_b, rd_c, wr_c;
  logic [63:0] wdata64;
  logic [7:0]  be8;
  logic [31:0] rdata_a, rdata_b;
  logic [63:0] rdata_c;
  logic        rdy_a, busy_a, rdy_b, busy_b, rdy_c, busy_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latency_mem #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .read(rd_a), .write(wr_a), .address(addr),
    .write_data(wdata), .byte_en(be), .read_data(rdata_a), .ready(rdy_a), .busy(busy_a)
  );

  latency_mem #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .read(rd_b), .write(wr_b), .address(addr),
    .write_data(wdata), .byte_en(be), .read_data(rdata_b), .ready(rdy_b), .busy(busy_b)
  );

  latency_mem #(.DATA_W(64), .DEPTH_LOG2(4), .LATENCY(2)) dut64 (
    .clk(clk), .reset(reset), .read(rd_c), .write(wr_c), .address(addr),
    .write_data(wdata64), .byte_en(be8), .read_data(rdata_c), .ready(rdy_c), .busy(busy_c)
  );

  task automatic write_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr_a = 1'b1;
    repeat (3) @(negedge clk);
    wr_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_b(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr_b = 1'b1;
    @(negedge clk);
    wr_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_c(input logic [31:0] a, input logic [63:0] d, input logic [7:0] b);
    addr = a; wdata64 = d; be8 = b; wr_c = 1'b1;
    repeat (3) @(negedge clk);
    wr_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    addr = '0; wdata = '0; be = '0; wdata64 = '0; be8 = '0;
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0; rd_c = 0; wr_c = 0;
    @(negedge clk);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL reset_ready_l0: got %b expected 0", rdy_b); end
    checks++; if (rdata_c !== 64'h0) begin errors++; $display("FAIL reset_rdata64: got %h expected 0", rdata_c); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read;
    write_a(32'hC8, 32'hDEADBEEF, 4'hF);
    addr = 32'hC8; rd_a = 1'b1;
    @(negedge clk);
    checks++; if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin errors++; $display("FAIL read_cyc1: got busy=%b ready=%b expected busy=1 ready=0", busy_a, rdy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin errors++; $display("FAIL read_cyc2: got busy=%b ready=%b expected busy=1 ready=0", busy_a, rdy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin errors++; $display("FAIL read_cyc3: got busy=%b ready=%b expected busy=0 ready=1", busy_a, rdy_a); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rdata_a); end
    rd_a = 1'b0;
    @(negedge clk);
    checks++; if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL read_after: got busy=%b ready=%b expected 0 0", busy_a, rdy_a); end
  endtask

  task automatic test_byte_en;
    addr = 32'hC8; wdata = 32'h11223344; be = 4'b0101; wr_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL be_ready: got %b expected 1", rdy_a); end
    wr_a = 1'b0;
    @(negedge clk);
    checks++; if (dut.mem_data[50] !== 32'hDE22BE44) begin errors++; $display("FAIL be_mem: got %h expected de22be44", dut.mem_data[50]); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL be_rdata_hold: got %h expected deadbeef", rdata_a); end
  endtask

  task automatic test_both_high;
    addr = 32'h1000; wdata = 32'hA5A5A5A5; be = 4'hF; rd_a = 1'b1; wr_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL both_ready: got %b expected 1", rdy_a); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rdata_hold: got %h expected deadbeef", rdata_a); end
    rd_a = 1'b0; wr_a = 1'b0;
    @(negedge clk);
    checks++; if (dut.mem_data[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_mem0: got %h expected a5a5a5a5", dut.mem_data[0]); end
  endtask

  task automatic test_back_to_back;
    addr = 32'hC8; rd_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_a !== 1'b1 || rdata_a !== 32'hDE22BE44) begin errors++; $display("FAIL b2b_first: got ready=%b data=%h expected 1 de22be44", rdy_a, rdata_a); end
    addr = 32'h1000;
    @(negedge clk);
    checks++; if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b ready=%b expected 0 0", busy_a, rdy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy_a); end
    repeat (2) @(negedge clk);
    checks++; if (rdy_a !== 1'b1 || rdata_a !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_second: got ready=%b data=%h expected 1 a5a5a5a5", rdy_a, rdata_a); end
    rd_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop_during_wait;
    addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF; wr_a = 1'b1;
    @(negedge clk);
    wr_a = 1'b0; addr = 32'hC8; wdata = 32'h0; be = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b expected 1", rdy_a); end
    @(negedge clk);
    checks++; if (dut.mem_data[8] !== 32'hCAFEF00D) begin errors++; $display("FAIL drop_mem8: got %h expected cafef00d", dut.mem_data[8]); end
    checks++; if (dut.mem_data[50] !== 32'hDE22BE44) begin errors++; $display("FAIL drop_mem50: got %h expected de22be44", dut.mem_data[50]); end
  endtask

  task automatic test_reset_mid;
    write_a(32'h1C, 32'h77777777, 4'hF);
    addr = 32'h1C; wdata = 32'h12345678; be = 4'hF; wr_a = 1'b1;
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b expected 1", busy_a); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0 || rdy_a !== 1'b0) begin errors++; $display("FAIL rstmid_immediate: got busy=%b ready=%b expected 0 0", busy_a, rdy_a); end
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", rdata_a); end
    wr_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rstmid_no_ready1: got %b expected 0", rdy_a); end
    @(negedge clk);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rstmid_no_ready2: got %b expected 0", rdy_a); end
    checks++; if (dut.mem_data[7] !== 32'h77777777) begin errors++; $display("FAIL rstmid_mem7: got %h expected 77777777", dut.mem_data[7]); end
    rd_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_a !== 1'b1 || rdata_a !== 32'h77777777) begin errors++; $display("FAIL rstmid_next_read: got ready=%b data=%h expected 1 77777777", rdy_a, rdata_a); end
    rd_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency0;
    write_b(32'hC, 32'h33333333, 4'hF);
    write_b(32'h10, 32'h44444444, 4'hF);
    addr = 32'hC; rd_b = 1'b1;
    @(negedge clk);
    checks++; if (rdy_b !== 1'b1 || rdata_b !== 32'h33333333) begin errors++; $display("FAIL l0_p1: got ready=%b data=%h expected 1 33333333", rdy_b, rdata_b); end
    addr = 32'h10;
    @(negedge clk);
    checks++; if (rdy_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL l0_gap1: got ready=%b busy=%b expected 0 0", rdy_b, busy_b); end
    @(negedge clk);
    checks++; if (rdy_b !== 1'b1 || rdata_b !== 32'h44444444) begin errors++; $display("FAIL l0_p2: got ready=%b data=%h expected 1 44444444", rdy_b, rdata_b); end
    addr = 32'hC;
    @(negedge clk);
    checks++; if (rdy_b !== 1'b0 || rdata_b !== 32'h44444444) begin errors++; $display("FAIL l0_gap2: got ready=%b data=%h expected 0 44444444", rdy_b, rdata_b); end
    @(negedge clk);
    checks++; if (rdy_b !== 1'b1 || rdata_b !== 32'h33333333) begin errors++; $display("FAIL l0_p3: got ready=%b data=%h expected 1 33333333", rdy_b, rdata_b); end
    rd_b = 1'b0;
    @(negedge clk);
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL l0_end: got %b expected 0", rdy_b); end
  endtask

  task automatic test_wide;
    write_c(32'h44, 64'h0123456789ABCDEF, 8'hFF);
    checks++; if (dut64.mem_data[1] !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL wide_mem1: got %h expected 0123456789abcdef", dut64.mem_data[1]); end
    addr = 32'h44; rd_c = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rdy_c !== 1'b0 || busy_c !== 1'b1) begin errors++; $display("FAIL wide_wait: got ready=%b busy=%b expected 0 1", rdy_c, busy_c); end
    @(negedge clk);
    checks++; if (rdy_c !== 1'b1 || rdata_c !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL wide_read: got ready=%b data=%h expected 1 0123456789abcdef", rdy_c, rdata_c); end
    rd_c = 1'b0;
    @(negedge clk);
    write_c(32'h04, 64'hFFFFFFFF00000000, 8'hF0);
    addr = 32'h84; rd_c = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_c !== 1'b1 || rdata_c !== 64'hFFFFFFFF89ABCDEF) begin errors++; $display("FAIL wide_partial: got ready=%b data=%h expected 1 ffffffff89abcdef", rdy_c, rdata_c); end
    rd_c = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_read;
    test_byte_en;
    test_both_high;
    test_back_to_back;
    test_drop_during_wait;
    test_reset_mid;
    test_latency0;
    test_wide;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
